// File: rtl/i2c_reg_sequencer_if.sv
// ---------------------------------------------------------------------------
// i2c_reg_sequencer_if
//   Command channel between the register sequencer (master) and the I2C bit
//   driver (slave).
//
//   i2c_start       START command level (master -> slave)
//   i2c_stop        STOP command level (master -> slave)
//   i2c_write       WRITE-byte command level (master -> slave)
//   i2c_data[7:0]   byte to send, stable while i2c_write is high
//   i2c_cmd_done    one-cycle command-complete pulse (slave -> master)
//   i2c_cmd_status  ACK(1)/NACK(0) qualifier of i2c_cmd_done for WRITE
// ---------------------------------------------------------------------------
interface i2c_reg_sequencer_if;
    logic       i2c_start;
    logic       i2c_stop;
    logic       i2c_write;
    logic [7:0] i2c_data;
    logic       i2c_cmd_done;
    logic       i2c_cmd_status;

    modport master (
        output i2c_start, i2c_stop, i2c_write, i2c_data,
        input  i2c_cmd_done, i2c_cmd_status
    );

    modport slave (
        input  i2c_start, i2c_stop, i2c_write, i2c_data,
        output i2c_cmd_done, i2c_cmd_status
    );
endinterface

// File: rtl/i2c_reg_sequencer.sv
// ---------------------------------------------------------------------------
// i2c_reg_sequencer
//   Walks a register table after power-up and programs the audio codec by
//   issuing one 3-byte I2C write per entry (addr+W, word[15:8], word[7:0])
//   through the I2C bit driver. Retries an entry after a NACK, guards every
//   command with a watchdog and leaves a bus-idle gap after each STOP.
//
//   sys_clk         system clock
//   rst             asynchronous active-high reset
//   go              start request, sampled only while idle
//   busy            sequence in progress (from accepted go until done)
//   done            one-cycle pulse at sequence end
//   error           sticky failure flag, cleared by the next accepted go
//   tbl_idx[3:0]    table index to the external ROM
//   tbl_word[15:0]  ROM word for tbl_idx (combinational)
//   bus             command channel to the I2C bit driver (master side)
// ---------------------------------------------------------------------------
module i2c_reg_sequencer #(
    parameter logic [6:0] DEV_ADDR   = 7'h1A,
    parameter int          NUM_REGS   = 10,
    parameter int          RETRIES    = 3,
    parameter int          GAP_CYCLES = 16,
    parameter int          TIMEOUT    = 255
) (
    input  logic                       sys_clk,
    input  logic                       rst,
    input  logic                       go,
    output logic                       busy,
    output logic                       done,
    output logic                       error,
    output logic [3:0]                 tbl_idx,
    input  logic [15:0]                tbl_word,
    i2c_reg_sequencer_if.master        bus
);

    localparam int RETRY_W = (RETRIES < 1) ? 1 : $clog2(RETRIES + 1);
    localparam int GAP_W   = $clog2(GAP_CYCLES + 1);
    localparam int WD_W    = $clog2(TIMEOUT + 1);

    typedef enum logic [3:0] {
        S_IDLE, S_LOAD, S_START, S_RELEASE, S_ADDR,
        S_HI, S_LO, S_STOP, S_GAP, S_FINISH
    } state_t;

    state_t               state, state_n;
    state_t               after_rel, after_rel_n;   // where RELEASE goes next
    logic [15:0]          word, word_n;
    logic [3:0]           idx, idx_n;
    logic [RETRY_W-1:0]   retry, retry_n;
    logic                 nack, nack_n;
    logic                 err, err_n;
    logic [GAP_W-1:0]     gap_cnt;
    logic [WD_W-1:0]      wd_cnt;

    logic                 in_cmd;
    logic                 wd_expired;
    logic                 gap_last;
    logic                 cmd_start, cmd_stop, cmd_write;
    logic [7:0]           cmd_data;

    always_comb begin
        // NOTE: every signal driven here gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        state_n     = state;
        after_rel_n = after_rel;
        word_n      = word;
        idx_n       = idx;
        retry_n     = retry;
        nack_n      = nack;
        err_n       = err;
        cmd_start   = 1'b0;
        cmd_stop    = 1'b0;
        cmd_write   = 1'b0;
        cmd_data    = 8'h00;

        in_cmd     = (state inside {S_START, S_ADDR, S_HI, S_LO, S_STOP});
        wd_expired = in_cmd && !bus.i2c_cmd_done && (wd_cnt == WD_W'(TIMEOUT - 1));
        gap_last   = (gap_cnt == GAP_W'(GAP_CYCLES - 1));

        case (state)
            S_IDLE: begin
                if (go) begin
                    state_n = S_LOAD;
                    err_n   = 1'b0;
                    idx_n   = 4'd0;
                    retry_n = '0;
                end
            end
            S_LOAD: begin
                word_n  = tbl_word;
                nack_n  = 1'b0;
                state_n = S_START;
            end
            S_START: begin
                cmd_start = 1'b1;
                if (bus.i2c_cmd_done) begin
                    after_rel_n = S_ADDR;
                    state_n     = S_RELEASE;
                end
            end
            S_RELEASE: state_n = after_rel;
            S_ADDR, S_HI, S_LO: begin
                cmd_write = 1'b1;
                cmd_data  = (state == S_ADDR) ? {DEV_ADDR, 1'b0} :
                            (state == S_HI)   ? word[15:8] : word[7:0];
                if (bus.i2c_cmd_done) begin
                    state_n = S_RELEASE;
                    if (!bus.i2c_cmd_status) begin
                        nack_n      = 1'b1;
                        after_rel_n = S_STOP;
                    end else begin
                        after_rel_n = (state == S_ADDR) ? S_HI :
                                      (state == S_HI)   ? S_LO : S_STOP;
                    end
                end
            end
            S_STOP: begin
                cmd_stop = 1'b1;
                if (bus.i2c_cmd_done) begin
                    after_rel_n = S_GAP;
                    state_n     = S_RELEASE;
                end
            end
            S_GAP: begin
                if (gap_last) begin
                    if (!nack) begin
                        if (idx == 4'(NUM_REGS - 1)) begin
                            state_n = S_FINISH;
                        end else begin
                            idx_n   = idx + 4'd1;
                            retry_n = '0;
                            state_n = S_LOAD;
                        end
                    end else if (retry < RETRY_W'(RETRIES)) begin
                        retry_n = retry + RETRY_W'(1);
                        state_n = S_LOAD;
                    end else begin
                        err_n   = 1'b1;
                        state_n = S_FINISH;
                    end
                end
            end
            S_FINISH: state_n = S_IDLE;
            default:  state_n = S_IDLE;
        endcase

        // Watchdog expiry abandons the transaction without a STOP; the
        // command line falls when FINISH is entered on the next cycle.
        if (wd_expired) begin
            state_n = S_FINISH;
            err_n   = 1'b1;
        end
    end

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            after_rel <= S_IDLE;
            word      <= 16'h0000;
            idx       <= 4'd0;
            retry     <= '0;
            nack      <= 1'b0;
            err       <= 1'b0;
            gap_cnt   <= '0;
            wd_cnt    <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values, independent of statement order.
            state     <= state_n;
            after_rel <= after_rel_n;
            word      <= word_n;
            idx       <= idx_n;
            retry     <= retry_n;
            nack      <= nack_n;
            err       <= err_n;
            gap_cnt   <= (state == S_GAP) ? gap_cnt + GAP_W'(1) : '0;
            // Cleared in every non-command state, so it restarts from zero on
            // entry to each command.
            wd_cnt    <= in_cmd ? wd_cnt + WD_W'(1) : '0;
        end
    end

    // Command lines decode straight from the state register so an async
    // reset drops them in the same cycle.
    assign bus.i2c_start = cmd_start;
    assign bus.i2c_stop  = cmd_stop;
    assign bus.i2c_write = cmd_write;
    assign bus.i2c_data  = cmd_data;

    assign busy    = (state != S_IDLE) && (state != S_FINISH);
    assign done    = (state == S_FINISH);
    assign error   = err;
    assign tbl_idx = idx;

endmodule

// File: tb/tb_i2c_reg_sequencer.sv
// ---------------------------------------------------------------------------
// tb_i2c_reg_sequencer
//   Self-checking bench: a behavioural I2C driver responds to commands with
//   random latency and a planned ACK/NACK pattern; a reference model derives
//   the expected command stream from the table and the same NACK plan.
// ---------------------------------------------------------------------------
module tb_i2c_reg_sequencer;

    localparam int         NUM_REGS   = 2;
    localparam int         RETRIES    = 3;
    localparam int         GAP_CYCLES = 16;
    localparam int         TIMEOUT    = 255;
    localparam logic [7:0] ADDR_BYTE  = 8'h34;

    localparam logic [1:0] C_START = 2'd1;
    localparam logic [1:0] C_STOP  = 2'd2;
    localparam logic [1:0] C_WRITE = 2'd3;

    logic        sys_clk = 1'b0;
    logic        rst;
    logic        go;
    logic        busy, done, error;
    logic [3:0]  tbl_idx;
    logic [15:0] tbl_word;
    logic [15:0] table_mem [16];

    i2c_reg_sequencer_if bus ();

    i2c_reg_sequencer #(
        .DEV_ADDR   (7'h1A),
        .NUM_REGS   (NUM_REGS),
        .RETRIES    (RETRIES),
        .GAP_CYCLES (GAP_CYCLES),
        .TIMEOUT    (TIMEOUT)
    ) dut (
        .sys_clk  (sys_clk),
        .rst      (rst),
        .go       (go),
        .busy     (busy),
        .done     (done),
        .error    (error),
        .tbl_idx  (tbl_idx),
        .tbl_word (tbl_word),
        .bus      (bus)
    );

    always #5 sys_clk = ~sys_clk;

    assign tbl_word = table_mem[tbl_idx];

    int n_assert = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------- behavioural I2C driver ----------------
    // nack_plan holds, per transaction attempt, the write index (0=addr,
    // 1=hi, 2=lo) that is NACKed; 3 (or an empty plan) means all ACK.
    int nack_plan[$];
    bit hang_start   = 1'b0;
    bit inject_stray = 1'b0;

    initial begin
        int lat;
        bit responded;
        int wr_idx;
        int cur_nack;
        lat       = -1;
        responded = 1'b0;
        wr_idx    = 0;
        cur_nack  = 3;
        bus.i2c_cmd_done   = 1'b0;
        bus.i2c_cmd_status = 1'b0;
        forever begin
            @(negedge sys_clk);
            bus.i2c_cmd_done   = 1'b0;
            bus.i2c_cmd_status = 1'b0;
            if (rst || !(bus.i2c_start || bus.i2c_stop || bus.i2c_write)) begin
                lat       = -1;
                responded = 1'b0;
                if (!rst && inject_stray) begin
                    bus.i2c_cmd_done   = 1'b1;
                    bus.i2c_cmd_status = 1'b1;
                    inject_stray       = 1'b0;
                end
            end else if (!responded) begin
                if (lat < 0) begin
                    lat = int'($urandom_range(0, 3));
                    if (bus.i2c_start) begin
                        wr_idx   = 0;
                        cur_nack = (nack_plan.size() > 0) ? nack_plan.pop_front() : 3;
                    end
                end
                if (lat == 0) begin
                    if (!(bus.i2c_start && hang_start)) begin
                        bus.i2c_cmd_done = 1'b1;
                        responded        = 1'b1;
                        if (bus.i2c_write) begin
                            bus.i2c_cmd_status = (wr_idx != cur_nack);
                            wr_idx++;
                        end else begin
                            bus.i2c_cmd_status = 1'($urandom_range(0, 1));
                        end
                    end
                end else begin
                    lat--;
                end
            end
        end
    end

    // ---------------- bus monitor ----------------
    logic [9:0] log_q[$];
    int         start_len = 0;

    initial begin
        int         idle_run;
        int         start_run;
        bit         stop_seen;
        logic       pstart, pstop, pwrite;
        logic [7:0] pdata;
        idle_run  = 0;
        start_run = 0;
        stop_seen = 1'b0;
        pstart    = 1'b0;
        pstop     = 1'b0;
        pwrite    = 1'b0;
        pdata     = 8'h00;
        forever begin
            @(negedge sys_clk);
            if (rst) begin
                idle_run  = 0;
                stop_seen = 1'b0;
                pstart    = 1'b0;
                pstop     = 1'b0;
                pwrite    = 1'b0;
            end else begin
                if (bus.i2c_start || bus.i2c_stop || bus.i2c_write) begin
                    check("cmd_onehot",
                          32'(int'(bus.i2c_start) + int'(bus.i2c_stop) + int'(bus.i2c_write)), 1);
                end
                if (busy) check("tbl_idx_range", 32'(tbl_idx < NUM_REGS), 1);
                if (bus.i2c_start && !pstart) begin
                    log_q.push_back({C_START, 8'h00});
                    if (stop_seen) check("bus_idle_gap", 32'(idle_run >= GAP_CYCLES), 1);
                    stop_seen = 1'b0;
                    start_run = 0;
                end
                if (bus.i2c_write && !pwrite) begin
                    log_q.push_back({C_WRITE, bus.i2c_data});
                    check("release_gap_w", idle_run, 1);
                end
                if (bus.i2c_stop && !pstop) begin
                    log_q.push_back({C_STOP, 8'h00});
                    check("release_gap_p", idle_run, 1);
                end
                if (bus.i2c_write && pwrite) check("data_stable", bus.i2c_data, pdata);
                if (bus.i2c_start) start_run++;
                else if (pstart) start_len = start_run;
                if (bus.i2c_stop) stop_seen = 1'b1;
                if (bus.i2c_start || bus.i2c_stop || bus.i2c_write) idle_run = 0;
                else idle_run++;
                if (done) stop_seen = 1'b0;
                pstart = bus.i2c_start;
                pstop  = bus.i2c_stop;
                pwrite = bus.i2c_write;
                pdata  = bus.i2c_data;
            end
        end
    end

    // ---------------- reference model ----------------
    task automatic build_expected(input int plan[$], output logic [9:0] exp_q[$], output bit exp_err);
        int idx;
        int retry;
        int p;
        int n;
        logic [7:0] bytes [3];
        idx     = 0;
        retry   = 0;
        p       = 0;
        exp_q   = {};
        exp_err = 1'b0;
        while (1) begin
            bytes[0] = ADDR_BYTE;
            bytes[1] = table_mem[idx][15:8];
            bytes[2] = table_mem[idx][7:0];
            n = (p < plan.size()) ? plan[p] : 3;
            p++;
            exp_q.push_back({C_START, 8'h00});
            for (int k = 0; k < 3; k++) begin
                exp_q.push_back({C_WRITE, bytes[k]});
                if (k == n) break;
            end
            exp_q.push_back({C_STOP, 8'h00});
            if (n < 3) begin
                if (retry < RETRIES) retry++;
                else begin
                    exp_err = 1'b1;
                    break;
                end
            end else begin
                retry = 0;
                idx++;
                if (idx == NUM_REGS) break;
            end
        end
    endtask

    // mode: 0 normal, 1 go-while-busy plus stray cmd_done, 2 START never completes
    task automatic run_seq(input string name, input int plan[$], input int mode);
        logic [9:0] exp_q[$];
        bit         exp_err;
        bit         got;
        int         stray_cnt;
        if (mode == 2) begin
            exp_q = {};
            exp_q.push_back({C_START, 8'h00});
            exp_err = 1'b1;
        end else begin
            build_expected(plan, exp_q, exp_err);
        end
        nack_plan  = plan;
        log_q      = {};
        hang_start = (mode == 2);
        stray_cnt  = -1;
        got        = 1'b0;
        @(negedge sys_clk);
        go = 1'b1;
        @(negedge sys_clk);
        go = 1'b0;
        check({name, "_busy_on_go"}, busy, 1);
        check({name, "_error_cleared"}, error, 0);
        for (int c = 0; c < 20000; c++) begin
            @(negedge sys_clk);
            go = (mode == 1) && (c == 20 || c == 60);
            if (mode == 1 && bus.i2c_stop && stray_cnt < 0) stray_cnt = 3;
            if (stray_cnt > 0) begin
                stray_cnt--;
                if (stray_cnt == 0) inject_stray = 1'b1;
            end
            if (done) begin
                got = 1'b1;
                break;
            end
        end
        go = 1'b0;
        check({name, "_done_seen"}, got, 1);
        check({name, "_busy_at_done"}, busy, 0);
        check({name, "_error_at_done"}, error, exp_err);
        @(negedge sys_clk);
        check({name, "_done_width"}, done, 0);
        check({name, "_error_sticky"}, error, exp_err);
        if (mode == 2) begin
            check({name, "_start_cycles"}, start_len, TIMEOUT);
            check({name, "_start_dropped"}, bus.i2c_start, 0);
        end
        check({name, "_cmd_count"}, log_q.size(), exp_q.size());
        for (int i = 0; i < log_q.size() && i < exp_q.size(); i++) begin
            check($sformatf("%s_cmd%0d", name, i), log_q[i], exp_q[i]);
        end
        hang_start = 1'b0;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int  plan[$];
        bit  found;
        rst = 1'b1;
        go  = 1'b0;
        for (int i = 0; i < 16; i++) table_mem[i] = 16'h0000;
        table_mem[0] = 16'h1E00;
        table_mem[1] = 16'h0C10;

        repeat (3) @(negedge sys_clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_error", error, 0);
        check("rst_tbl_idx", tbl_idx, 0);
        check("rst_cmds", {bus.i2c_start, bus.i2c_stop, bus.i2c_write}, 0);
        check("rst_data", bus.i2c_data, 0);
        rst = 1'b0;
        repeat (2) @(negedge sys_clk);

        plan = {};
        run_seq("basic", plan, 0);

        plan = {};
        plan.push_back(0);
        run_seq("nack_addr", plan, 0);

        plan = {};
        for (int i = 0; i <= RETRIES; i++) plan.push_back(1);
        run_seq("nack_hi", plan, 0);

        plan = {};
        run_seq("timeout", plan, 2);

        // Reset in the middle of the HI byte of entry 0.
        nack_plan = {};
        log_q     = {};
        found     = 1'b0;
        @(negedge sys_clk);
        go = 1'b1;
        @(negedge sys_clk);
        go = 1'b0;
        for (int c = 0; c < 2000; c++) begin
            @(negedge sys_clk);
            if (bus.i2c_write && bus.i2c_data == 8'h1E) begin
                found = 1'b1;
                break;
            end
        end
        check("mid_rst_hi_seen", found, 1);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_cmds", {bus.i2c_start, bus.i2c_stop, bus.i2c_write}, 0);
        check("mid_rst_data", bus.i2c_data, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_tbl_idx", tbl_idx, 0);
        @(negedge sys_clk);
        rst = 1'b0;
        repeat (2) @(negedge sys_clk);
        check("post_rst_stop_absent", 32'(log_q.size() > 0 && log_q[log_q.size()-1][9:8] == C_STOP), 0);
        plan = {};
        run_seq("after_rst", plan, 0);

        plan = {};
        run_seq("stray", plan, 1);

        for (int r = 0; r < 3; r++) begin
            table_mem[0] = 16'($urandom);
            table_mem[1] = 16'($urandom);
            plan = {};
            for (int a = 0; a < 10; a++) begin
                plan.push_back(($urandom_range(0, 99) < 30) ? int'($urandom_range(0, 2)) : 3);
            end
            run_seq($sformatf("rand%0d", r), plan, 0);
        end

        repeat (5) @(negedge sys_clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
